// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master arbiter for one segment port of the segmented memory.
// m0 (CPU data port) and m1 (auxiliary master) share the segment. Exactly one
// master owns the port per cycle. Ownership is round-robin with a burst limit:
// the owner keeps the port for at most MAX_BURST consecutive cycles while the
// other master is waiting. Read data returns to the granted master one cycle
// after the grant.
module mem_arbiter #(
    parameter int AW        = 10,
    parameter int DW        = 16,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    // master 0: CPU data port
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    // master 1: auxiliary master
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    // memory segment port
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    // The burst counter must be able to hold MAX_BURST itself.
    localparam int            CW      = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          last_q, last_d;   // master served most recently (0/1)
    logic [CW-1:0] cnt_q, cnt_d;     // consecutive cycles served to the owner

    logic          gnt0, gnt1;

    // Grant decision: at most one grant per cycle.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path through
        // the case statement can leave it unassigned and infer a latch.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        unique case (state_q)
            OWN0: begin
                if (m0_req && ((cnt_q < MAX_CNT) || !m1_req)) gnt0 = 1'b1;
                else if (m1_req)                              gnt1 = 1'b1;
            end
            OWN1: begin
                if (m1_req && ((cnt_q < MAX_CNT) || !m0_req)) gnt1 = 1'b1;
                else if (m0_req)                              gnt0 = 1'b1;
            end
            default: begin
                // IDLE: a tie goes to the master that was not served last.
                if (m0_req && m1_req) begin
                    if (last_q) gnt0 = 1'b1;
                    else        gnt1 = 1'b1;
                end else if (m0_req) begin
                    gnt0 = 1'b1;
                end else if (m1_req) begin
                    gnt1 = 1'b1;
                end
            end
        endcase
    end

    // Next ownership state, last-served master and burst counter.
    always_comb begin
        state_d = IDLE;
        last_d  = last_q;
        cnt_d   = '0;
        if (gnt0) begin
            state_d = OWN0;
            last_d  = 1'b0;
            if (state_q == OWN0) cnt_d = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + 1'b1;
            else                 cnt_d = CW'(1);
        end else if (gnt1) begin
            state_d = OWN1;
            last_d  = 1'b1;
            if (state_q == OWN1) cnt_d = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + 1'b1;
            else                 cnt_d = CW'(1);
        end
    end

    // Arbiter state register; last=1 so m0 wins the first tie after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Memory port follows the granted master; parked at zero with no grant.
    always_comb begin
        mem_we = 1'b0;
        mem_a  = '0;
        mem_wd = '0;
        if (gnt0) begin
            mem_we = m0_we;
            mem_a  = m0_addr;
            mem_wd = m0_wdata;
        end else if (gnt1) begin
            mem_we = m1_we;
            mem_a  = m1_addr;
            mem_wd = m1_wdata;
        end
    end

    assign m0_gnt = gnt0;
    assign m1_gnt = gnt1;

    // Read return: capture segment data at the end of a granted read cycle.
    // rdata holds between reads; a reset drops any read still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= gnt0 && !m0_we;
            m1_rvalid <= gnt1 && !m1_we;
            if (gnt0 && !m0_we) m0_rdata <= mem_rd;
            if (gnt1 && !m1_we) m1_rdata <= mem_rd;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a behavioural memory segment
// (combinational read, write on the rising edge).
module tb_mem_arbiter;

    localparam int AW = 10;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd, mem_rd;

    int n_checks = 0;
    int n_pass   = 0;

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .mem_we    (mem_we),
        .mem_a     (mem_a),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd)
    );

    always #5 clk = ~clk;

    // Memory segment model.
    logic [DW-1:0] mem [0:(1<<AW)-1] = '{default: '0};
    assign mem_rd = mem[mem_a];
    always @(posedge clk) if (mem_we) mem[mem_a] <= mem_wd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
    endtask

    task automatic drive1(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
    endtask

    initial begin
        logic exp0;
        rst_n = 1'b0;
        drive0(1'b0, 1'b0, '0, '0);
        drive1(1'b0, 1'b0, '0, '0);
        #2;
        // Reset state.
        check("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
        check("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
        check("rst_m0_rdata",  32'(m0_rdata),  32'd0);
        check("rst_m1_rdata",  32'(m1_rdata),  32'd0);
        check("rst_mem_we",    32'(mem_we),    32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // m0 writes 0x5A5A to addr 3, then reads it back.
        drive0(1'b1, 1'b1, 10'd3, 16'h5A5A);
        #1;
        check("wr3_m0_gnt", 32'(m0_gnt), 32'd1);
        check("wr3_mem_we", 32'(mem_we), 32'd1);
        check("wr3_mem_wd", 32'(mem_wd), 32'h5A5A);
        tick();
        check("wr3_no_rvalid", 32'(m0_rvalid), 32'd0);
        drive0(1'b1, 1'b0, 10'd3, 16'h0);
        #1;
        check("rd3_mem_a", 32'(mem_a), 32'd3);
        tick();
        check("rd3_rvalid", 32'(m0_rvalid), 32'd1);
        check("rd3_rdata",  32'(m0_rdata),  32'h5A5A);

        // Reset in the middle of a granted read: the return is dropped.
        #1;
        check("midrst_m0_gnt", 32'(m0_gnt), 32'd1);
        rst_n = 1'b0;
        drive0(1'b0, 1'b0, '0, '0);
        tick();
        check("midrst_rvalid", 32'(m0_rvalid), 32'd0);
        check("midrst_rdata",  32'(m0_rdata),  32'd0);
        rst_n = 1'b1;
        #1;

        // First tie after reset goes to m0.
        drive0(1'b1, 1'b0, 10'd3, '0);
        drive1(1'b1, 1'b0, 10'd4, '0);
        #1;
        check("tie_rst_m0_gnt", 32'(m0_gnt), 32'd1);
        check("tie_rst_m1_gnt", 32'(m1_gnt), 32'd0);
        tick();
        check("tie_rst_rvalid", 32'(m0_rvalid), 32'd1);
        check("tie_rst_rdata",  32'(m0_rdata),  32'h5A5A);
        drive0(1'b0, 1'b0, '0, '0);
        drive1(1'b0, 1'b0, '0, '0);
        #1;
        check("idle_no_gnt", 32'({m0_gnt, m1_gnt}), 32'd0);
        check("idle_mem_a",  32'(mem_a),  32'd0);
        check("idle_mem_we", 32'(mem_we), 32'd0);
        tick();
        check("rvalid_one_cycle", 32'(m0_rvalid), 32'd0);
        check("rdata_holds",      32'(m0_rdata),  32'h5A5A);

        // Tie from IDLE with m0 served last goes to m1.
        drive0(1'b1, 1'b0, 10'd3, '0);
        drive1(1'b1, 1'b0, 10'd4, '0);
        #1;
        check("tie_idle_m1_gnt", 32'(m1_gnt), 32'd1);
        check("tie_idle_m0_gnt", 32'(m0_gnt), 32'd0);
        drive0(1'b0, 1'b0, '0, '0);
        drive1(1'b0, 1'b0, '0, '0);
        tick();

        // m1 alone: write 0xBEEF to addr 5, then read it back.
        drive1(1'b1, 1'b1, 10'd5, 16'hBEEF);
        #1;
        check("m1wr_gnt",    32'(m1_gnt), 32'd1);
        check("m1wr_mem_we", 32'(mem_we), 32'd1);
        check("m1wr_mem_a",  32'(mem_a),  32'd5);
        check("m1wr_mem_wd", 32'(mem_wd), 32'hBEEF);
        tick();
        check("m1wr_no_rvalid", 32'(m1_rvalid), 32'd0);
        drive1(1'b1, 1'b0, 10'd5, '0);
        #1;
        check("m1rd_gnt",    32'(m1_gnt), 32'd1);
        check("m1rd_mem_we", 32'(mem_we), 32'd0);
        tick();
        check("m1rd_rvalid", 32'(m1_rvalid), 32'd1);
        check("m1rd_rdata",  32'(m1_rdata),  32'hBEEF);
        drive1(1'b0, 1'b0, '0, '0);
        tick();

        // Both request continuously: m0 x4, m1 x4, m0 x4 (m1 served last).
        drive0(1'b1, 1'b0, 10'd3, '0);
        drive1(1'b1, 1'b0, 10'd5, '0);
        for (int i = 0; i < 12; i++) begin
            exp0 = ((i / 4) % 2) == 0;
            #1;
            check($sformatf("burst%0d_m0_gnt", i), 32'(m0_gnt), 32'(exp0));
            check($sformatf("burst%0d_m1_gnt", i), 32'(m1_gnt), 32'(!exp0));
            tick();
            check($sformatf("burst%0d_m0_rvalid", i), 32'(m0_rvalid), 32'(exp0));
        end
        drive0(1'b0, 1'b0, '0, '0);
        drive1(1'b0, 1'b0, '0, '0);
        tick();

        // m0 alone for 10 cycles keeps the grant throughout.
        drive0(1'b1, 1'b0, 10'd3, '0);
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("solo%0d_m0_gnt", i), 32'(m0_gnt), 32'd1);
            tick();
        end
        // Counter saturated at the burst limit: m1 takes over immediately.
        drive1(1'b1, 1'b0, 10'd5, '0);
        #1;
        check("sat_m1_gnt", 32'(m1_gnt), 32'd1);
        check("sat_m0_gnt", 32'(m0_gnt), 32'd0);
        drive0(1'b0, 1'b0, '0, '0);
        drive1(1'b0, 1'b0, '0, '0);
        tick();

        // Handover coherence: m0 writes addr 7, m1 reads it the next cycle.
        drive0(1'b1, 1'b1, 10'd7, 16'h1234);
        #1;
        check("ho_wr_gnt", 32'(m0_gnt), 32'd1);
        tick();
        drive0(1'b0, 1'b0, '0, '0);
        drive1(1'b1, 1'b0, 10'd7, '0);
        #1;
        check("ho_rd_gnt",   32'(m1_gnt), 32'd1);
        check("ho_rd_mem_a", 32'(mem_a),  32'd7);
        tick();
        check("ho_rvalid", 32'(m1_rvalid), 32'd1);
        check("ho_rdata",  32'(m1_rdata),  32'h1234);
        drive1(1'b0, 1'b0, '0, '0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Mutual exclusion of grants, sampled away from the clock edge.
    always @(negedge clk) begin
        if (rst_n) begin
            assert (!(m0_gnt && m1_gnt))
            else $error("FAIL both_gnt: observed m0_gnt=%0b m1_gnt=%0b expected at most one", m0_gnt, m1_gnt);
        end
    end

endmodule
